// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Bridges the execute stage to a word-addressed data memory. It turns RISC-V
//   byte, halfword and word loads and stores into whole-word memory accesses.
//   Sub-word stores use a read-modify-write sequence. Load data is sign- or
//   zero-extended. Misaligned accesses and illegal funct3 codes complete with
//   an error response and never touch memory.
//
// Optional feature (macro LSU_ACCESS_COUNT_EN):
//   Adds saturating completion counters load_count, store_count and err_count.
//
// Ports:
//   clk, reset    rising-edge clock; asynchronous active-high reset
//   req_*         request from the core (accepted only while req_ready=1)
//   resp_*        one-cycle completion pulse with error flag and load data
//   mem_*         word interface to data memory (combinational read,
//                 write commits at the next rising clk edge)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    // Core request
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    // Core response
    output logic            resp_valid,
    output logic            resp_err,
    output logic [XLEN-1:0] resp_rdata,
    // Data memory
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_din,
    output logic            mem_read,
    output logic            mem_write,
    input  logic [XLEN-1:0] mem_out
`ifdef LSU_ACCESS_COUNT_EN
    ,
    output logic [31:0]     load_count,
    output logic [31:0]     store_count,
    output logic [31:0]     err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            state_q,  state_d;
    logic              we_q,     we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   addr_q,   addr_d;
    logic [XLEN-1:0]   wdata_q,  wdata_d;
    logic [XLEN-1:0]   din_q,    din_d;
    logic [XLEN-1:0]   rdata_q,  rdata_d;
    logic              err_q,    err_d;

    logic              accept;
    logic              req_bad;
    logic [XLEN-1:0]   lane;
    logic [XLEN-1:0]   load_val;
    logic [XLEN-1:0]   merged;

    // Request legality: funct3 must be a known width for the direction, and
    // the address must be naturally aligned for that width.
    always_comb begin
        req_bad = 1'b1;
        unique case (req_funct3)
            F3_B:         req_bad = 1'b0;
            F3_H:         req_bad = req_addr[0];
            F3_W:         req_bad = (req_addr[1:0] != 2'b00);
            F3_BU:        req_bad = req_we;
            F3_HU:        req_bad = req_we | req_addr[0];
            default:      req_bad = 1'b1;
        endcase
    end

    assign accept = req_valid && (state_q == IDLE);

    // Lane extraction and sub-word merge, both driven by the latched byte
    // offset. Little-endian: byte offset k occupies bits [8k+7:8k].
    always_comb begin
        lane     = mem_out >> {addr_q[1:0], 3'b000};
        load_val = '0;
        unique case (funct3_q)
            F3_B:    load_val = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_val = {{16{lane[15]}}, lane[15:0]};
            F3_W:    load_val = mem_out;
            F3_BU:   load_val = {24'h0, lane[7:0]};
            F3_HU:   load_val = {16'h0, lane[15:0]};
            default: load_val = '0;
        endcase

        merged = mem_out;
        if (funct3_q == F3_B) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and datapath update.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    // SW writes wdata directly; sub-word stores overwrite this
                    // with the merged word at the end of RD.
                    din_d    = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_bad;
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    din_d   = merged;
                    state_d = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before this edge regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            din_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            din_q    <= din_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode directly from the state register; addr_q and din_q are
    // stable for the whole of RD and WR because they only change on accept
    // and at the RD->WR edge.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign mem_din    = din_q;
    assign mem_read   = (state_q == RD);
    // Gating with reset keeps a write from escaping while reset is asserted.
    assign mem_write  = (state_q == WR) && !reset;

`ifdef LSU_ACCESS_COUNT_EN
    logic [31:0] load_count_q,  load_count_d;
    logic [31:0] store_count_q, store_count_d;
    logic [31:0] err_count_q,   err_count_d;

    // Each completion bumps exactly one counter; errors never count as
    // loads or stores. Counters stick at all-ones.
    always_comb begin
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        err_count_d   = err_count_q;
        if (state_q == RESP) begin
            if (err_q) begin
                if (err_count_q != 32'hFFFF_FFFF) err_count_d = err_count_q + 32'd1;
            end else if (we_q) begin
                if (store_count_q != 32'hFFFF_FFFF) store_count_d = store_count_q + 32'd1;
            end else begin
                if (load_count_q != 32'hFFFF_FFFF) load_count_d = load_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count_q  <= '0;
            store_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign load_count  = load_count_q;
    assign store_count = store_count_q;
    assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed self-checking bench for load_store_unit. A small word memory model
// answers mem_read combinationally and commits mem_write on the rising edge.
// Define LSU_ACCESS_COUNT_EN to also check the completion counters.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_out;
`ifdef LSU_ACCESS_COUNT_EN
    logic [31:0] load_count;
    logic [31:0] store_count;
    logic [31:0] err_count;
`endif

    logic [31:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_out    (mem_out)
`ifdef LSU_ACCESS_COUNT_EN
        ,
        .load_count (load_count),
        .store_count(store_count),
        .err_count  (err_count)
`endif
    );

    assign mem_out = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_din;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to its response. Returns the latency in
    // cycles after the accept edge, the response fields, whether memory was
    // read or written, and the last word presented on mem_din while writing.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata,
                          output logic err, output logic saw_rd,
                          output logic saw_wr, output logic [31:0] din);
        logic got;
        @(negedge clk);
        check("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        lat = 0; rdata = '0; err = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0; din = '0;
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (mem_read) saw_rd = 1'b1;
            if (mem_write) begin
                saw_wr = 1'b1;
                din    = mem_din;
            end
            if (mem_read && mem_write) check("rd_wr_exclusive", 32'd1, 32'd0);
            if (resp_valid) begin
                got   = 1'b1;
                lat   = k;
                rdata = resp_rdata;
                err   = resp_err;
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        saw_rd;
    logic        saw_wr;
    logic [31:0] din;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[16] = 32'h8899_AABB;   // byte address 0x40
        mem[18] = 32'h1122_3344;   // byte address 0x48
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;

        // Reset state
        #12;
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'b0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_mem_read",   {31'b0, mem_read},   32'd0);
        check("rst_mem_write",  {31'b0, mem_write},  32'd0);
        check("rst_mem_addr",   mem_addr,            32'd0);
        check("rst_mem_din",    mem_din,             32'd0);
        @(negedge clk);
        reset = 1'b0;

        // LB 0x41 -> byte 0xAA sign-extended, latency 2, no write
        do_req(1'b0, 3'b000, 32'h41, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("lb_lat",   lat, 32'd2);
        check("lb_rdata", rdata, 32'hFFFF_FFAA);
        check("lb_err",   {31'b0, err}, 32'd0);
        check("lb_rd",    {31'b0, saw_rd}, 32'd1);
        check("lb_no_wr", {31'b0, saw_wr}, 32'd0);

        // LHU 0x42 -> 0x8899 zero-extended
        do_req(1'b0, 3'b101, 32'h42, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("lhu_rdata", rdata, 32'h0000_8899);

        // LH 0x42 -> 0x8899 sign-extended
        do_req(1'b0, 3'b001, 32'h42, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("lh_rdata", rdata, 32'hFFFF_8899);

        // LBU 0x40 -> 0xBB
        do_req(1'b0, 3'b100, 32'h40, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("lbu_rdata", rdata, 32'h0000_00BB);

        // LW 0x40
        do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("lw_rdata", rdata, 32'h8899_AABB);
        check("lw_lat",   lat, 32'd2);

        // SB 0x43 wdata 0x12345677 -> merged 0x7799AABB, latency 3
        do_req(1'b1, 3'b000, 32'h43, 32'h1234_5677, lat, rdata, err, saw_rd, saw_wr, din);
        check("sb_lat",   lat, 32'd3);
        check("sb_din",   din, 32'h7799_AABB);
        check("sb_rd",    {31'b0, saw_rd}, 32'd1);
        check("sb_rdata", rdata, 32'd0);
        check("sb_err",   {31'b0, err}, 32'd0);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("sb_readback", rdata, 32'h7799_AABB);

        // SW 0x44 -> single write, latency 2
        do_req(1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF, lat, rdata, err, saw_rd, saw_wr, din);
        check("sw_lat",   lat, 32'd2);
        check("sw_din",   din, 32'hDEAD_BEEF);
        check("sw_no_rd", {31'b0, saw_rd}, 32'd0);
        check("sw_mem",   mem[17], 32'hDEAD_BEEF);

        // SH 0x46 wdata 0x0000CAFE onto 0xDEADBEEF -> 0xCAFEBEEF
        do_req(1'b1, 3'b001, 32'h46, 32'h0000_CAFE, lat, rdata, err, saw_rd, saw_wr, din);
        check("sh_lat", lat, 32'd3);
        check("sh_din", din, 32'hCAFE_BEEF);

        // LH 0x45 misaligned -> error at N+1, no memory traffic
        do_req(1'b0, 3'b001, 32'h45, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("mis_lat",   lat, 32'd1);
        check("mis_err",   {31'b0, err}, 32'd1);
        check("mis_rdata", rdata, 32'd0);
        check("mis_no_rd", {31'b0, saw_rd}, 32'd0);
        check("mis_no_wr", {31'b0, saw_wr}, 32'd0);

        // Illegal funct3 011 load
        do_req(1'b0, 3'b011, 32'h40, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("f3_011_err", {31'b0, err}, 32'd1);
        check("f3_011_lat", lat, 32'd1);

        // Store with load-only funct3 100 is illegal; memory untouched
        do_req(1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, lat, rdata, err, saw_rd, saw_wr, din);
        check("sbu_err",   {31'b0, err}, 32'd1);
        check("sbu_no_wr", {31'b0, saw_wr}, 32'd0);
        check("sbu_mem",   mem[16], 32'h7799_AABB);

        // LW 0x42 misaligned word
        do_req(1'b0, 3'b010, 32'h42, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        check("lw_mis_err", {31'b0, err}, 32'd1);

        // Reset during the WR cycle of SH 0x48
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h48; req_wdata = 32'h0000_5555;
        @(posedge clk);          // accept; RD follows
        #1 req_valid = 1'b0;
        @(posedge clk);          // RD -> WR
        #1;
        check("rst_wr_active", {31'b0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_wr_dropped", {31'b0, mem_write}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_mem",   mem[18], 32'h1122_3344);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);
        end

`ifdef LSU_ACCESS_COUNT_EN
        // Counters restarted at reset: 3 loads, 2 stores, 1 misaligned
        check("cnt_rst_load", load_count, 32'd0);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        do_req(1'b0, 3'b000, 32'h41, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        do_req(1'b0, 3'b101, 32'h42, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        do_req(1'b1, 3'b010, 32'h50, 32'h1, lat, rdata, err, saw_rd, saw_wr, din);
        do_req(1'b1, 3'b000, 32'h51, 32'h2, lat, rdata, err, saw_rd, saw_wr, din);
        do_req(1'b0, 3'b010, 32'h41, 32'h0, lat, rdata, err, saw_rd, saw_wr, din);
        @(negedge clk);
        check("cnt_load",  load_count,  32'd3);
        check("cnt_store", store_count, 32'd2);
        check("cnt_err",   err_count,   32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory.
- Converts RISC-V byte, halfword and word loads and stores into whole-word memory accesses.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Request/response handshake toward the core; misaligned and illegal accesses are reported without touching memory.

Parameters:
- XLEN, 32, data and address width (fixed at 32; the parameter exists only for port declarations).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  core presents an access
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 (width and sign)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  qualifies resp_valid: misaligned or illegal funct3
- resp_rdata  output  32  extended load data; 0 for stores and errors
- mem_addr  output  32  {addr[31:2],2'b00} to data memory
- mem_din  output  32  full word to write
- mem_read  output  1  read enable; memory read is combinational
- mem_write  output  1  write enable; write commits at the next rising clk edge
- mem_out  input  32  word returned by memory

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
- Reset asserted mid-operation:
  - Returns to IDLE immediately.
  - mem_write deasserts combinationally, so no partial write occurs.
  - No response is issued.
- IDLE, request accepted (req_valid & req_ready): latch we, funct3, addr, wdata, then check the request.
  - Illegal funct3 or misaligned → RESP with err=1. No memory access. resp_valid is asserted in cycle N+1.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Load or sub-word store → RD. SW → WR.
- RD (one cycle):
  - mem_read=1; mem_out is sampled at the clock edge.
  - Load: extract the lane at byte offset addr[1:0], little-endian. LB/LH sign-extend; LBU/LHU zero-extend. Result goes to resp_rdata. Next state RESP.
  - SB/SH: merge the low byte/half of wdata into mem_out at the offset and register the merged word. Next state WR.
- WR (one cycle):
  - mem_write=1.
  - mem_din = wdata (SW) or the merged word (SB/SH).
  - Next state RESP.
- RESP (one cycle): resp_valid=1, then IDLE.
  - resp_valid is a pulse; the core cannot stall it.
  - req_ready returns high in the cycle after RESP.
- Latency from accept in cycle N to the resp_valid cycle:
  - error: N+1
  - load: N+2
  - SW: N+2
  - SB/SH: N+3
- Interface rules:
  - req_* are ignored outside IDLE.
  - mem_addr and mem_din are held stable throughout RD/WR.
  - mem_read and mem_write are never both high.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after RESP.

Optional Feature:
- Macro: LSU_ACCESS_COUNT_EN.
- Defined:
  - Adds outputs load_count[31:0], store_count[31:0] and err_count[31:0].
  - Each counter increments by 1 in the RESP cycle of the matching completion type; error responses count only in err_count.
  - Counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counter logic do not exist; all other behaviour is identical.

Test Plan:
- Memory word 0x40 = 0x8899AABB; LB addr 0x41 → resp_valid at N+2, resp_rdata=0xFFFFFFAA, resp_err=0, mem_write never asserted.
- Same word; LHU addr 0x42 → resp_rdata=0x00008899; LW addr 0x40 → 0x8899AABB.
- SB addr 0x43, wdata 0x12345677 → RD then WR with mem_din=0x7799AABB, resp_valid at N+3; subsequent LW 0x40 returns 0x7799AABB.
- SW addr 0x44, wdata 0xDEADBEEF → single WR cycle, mem_din=0xDEADBEEF, resp at N+2; LH addr 0x45 → resp_err=1 at N+1, no mem_read/mem_write; funct3=011 → resp_err=1.
- Assert reset during the WR cycle of an SH → mem_write drops the same cycle, memory word unchanged, no resp_valid, req_ready=1 after reset.
- With LSU_ACCESS_COUNT_EN: 3 loads, 2 stores, 1 misaligned → load_count=3, store_count=2, err_count=1.
